piso_shift_register_8_bits: RTL and testbench

Parallel-to-serial shift stage directly downstream of the 8-bit PIPO register. It accepts one parallel word per valid/ready handshake and shifts it out one bit per accepted serial beat. The serial side has backpressure (Serial_Ready_In). Back-to-back words stream with no idle cycle between frames.

---
 rtl/piso_shift_register_8_bits_pkg.sv | 15 +
 rtl/piso_shift_register_8_bits_bit_counter.sv | 32 +++
 rtl/piso_shift_register_8_bits.sv | 86 ++++++++
 tb/tb_piso_shift_register_8_bits.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/piso_shift_register_8_bits_pkg.sv
// Shared types and helpers for the parallel-to-serial shift stage.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/piso_shift_register_8_bits_bit_counter.sv
// Bit-position counter for one serial frame; saturates on the last bit and
// only returns to zero through clear (a new word being loaded).
module bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic Clk_In,
  input  logic Reset_In,
  input  logic clear,
  input  logic enable,
  output logic is_last
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [CW-1:0] count;

  assign is_last = (count == LAST_IDX);

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !is_last) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/piso_shift_register_8_bits.sv
// Parallel-to-serial shift stage with valid/ready on both sides; a load on
// the final beat chains the next word so frames stream without gaps.
//
// state | meaning
// IDLE  | no frame active, ready for a word, output parked at IDLE_LEVEL
// SHIFT | frame in progress, one bit per accepted serial beat
module piso_shift_register_8_bits
  import piso_pkg::*;
#(
  parameter int   DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  input  logic                  Load_Valid_In,
  output logic                  Load_Ready_Out,
  output logic                  Serial_Data_Out,
  output logic                  Serial_Valid_Out,
  input  logic                  Serial_Ready_In,
  output logic                  Last_Bit_Out,
  output logic                  Busy_Out
);

  piso_state_t           state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  cnt_last;
  logic                  load;
  logic                  beat;
  logic                  out_bit;

  assign Busy_Out         = (state == SHIFT);
  assign Serial_Valid_Out = Busy_Out;
  assign Last_Bit_Out     = Busy_Out && cnt_last;
  assign Load_Ready_Out   = (state == IDLE) || (Last_Bit_Out && Serial_Ready_In);

  assign load = Load_Valid_In && Load_Ready_Out;
  assign beat = Serial_Valid_Out && Serial_Ready_In;

  assign out_bit         = MSB_FIRST ? shift_reg[DATA_WIDTH-1] : shift_reg[0];
  assign Serial_Data_Out = Busy_Out ? out_bit : IDLE_LEVEL;

  // A load on the final beat restarts the count rather than advancing it.
  bit_counter #(
    .WIDTH (DATA_WIDTH)
  ) u_bit_counter (
    .Clk_In   (Clk_In),
    .Reset_In (Reset_In),
    .clear    (load),
    .enable   (beat && !load),
    .is_last  (cnt_last)
  );

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state     <= IDLE;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shift_reg <= Parallel_Data_In;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (load) begin
            shift_reg <= Parallel_Data_In;
          end else if (beat) begin
            if (MSB_FIRST) begin
              shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
            end else begin
              shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
            end
            if (cnt_last) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_shift_register_8_bits.sv
// Directed bench for the PISO stage: MSB-first instance plus an LSB-first one.
module tb_piso_shift_register_8_bits;

  logic       clk;
  logic       rst;
  logic [7:0] pdata;
  logic       lvalid;
  logic       lready;
  logic       sdata;
  logic       svalid;
  logic       sready;
  logic       last;
  logic       busy;

  logic       l_rst;
  logic [7:0] l_pdata;
  logic       l_lvalid;
  logic       l_lready;
  logic       l_sdata;
  logic       l_svalid;
  logic       l_sready;
  logic       l_last;
  logic       l_busy;

  int checks = 0;
  int errors = 0;

  piso_shift_register_8_bits #(
    .DATA_WIDTH (8),
    .MSB_FIRST  (1'b1),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .Clk_In           (clk),
    .Reset_In         (rst),
    .Parallel_Data_In (pdata),
    .Load_Valid_In    (lvalid),
    .Load_Ready_Out   (lready),
    .Serial_Data_Out  (sdata),
    .Serial_Valid_Out (svalid),
    .Serial_Ready_In  (sready),
    .Last_Bit_Out     (last),
    .Busy_Out         (busy)
  );

  piso_shift_register_8_bits #(
    .DATA_WIDTH (8),
    .MSB_FIRST  (1'b0),
    .IDLE_LEVEL (1'b0)
  ) dut_lsb (
    .Clk_In           (clk),
    .Reset_In         (l_rst),
    .Parallel_Data_In (l_pdata),
    .Load_Valid_In    (l_lvalid),
    .Load_Ready_Out   (l_lready),
    .Serial_Data_Out  (l_sdata),
    .Serial_Valid_Out (l_svalid),
    .Serial_Ready_In  (l_sready),
    .Last_Bit_Out     (l_last),
    .Busy_Out         (l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, svalid, 1'b0);
    chk({tag, "_data"},  sdata,  1'b0);
    chk({tag, "_last"},  last,   1'b0);
    chk({tag, "_busy"},  busy,   1'b0);
  endtask

  // Called on the first cycle after a load; walks all 8 bits of w (MSB first),
  // withholding ready for stall_len cycles when bit index stall_at is shown.
  task automatic expect_frame(input string tag, input logic [7:0] w,
                              input int stall_at, input int stall_len);
    int k = 0;
    int stalled = 0;
    int beats = 0;
    int cycles = 0;
    while (k < 8 && cycles < 40) begin
      sready = !(k == stall_at && stalled < stall_len);
      chk({tag, "_valid"}, svalid, 1'b1);
      chk({tag, "_bit"},   sdata,  w[7-k]);
      chk({tag, "_last"},  last,   (k == 7));
      if (!sready) stalled++;
      tick();
      cycles++;
      if (sready) begin
        k++;
        beats++;
      end
    end
    sready = 1'b1;
    checks++;
    assert (beats == 8)
    else begin
      errors++;
      $error("FAIL %s_beats observed=%0d expected=8", tag, beats);
    end
  endtask

  initial begin
    logic [15:0] pair;
    logic [7:0]  w;

    rst = 1'b1; pdata = '0; lvalid = 1'b0; sready = 1'b1;
    l_rst = 1'b1; l_pdata = '0; l_lvalid = 1'b0; l_sready = 1'b1;
    tick();
    chk_idle("reset");
    chk("reset_lready", lready, 1'b1);
    tick();
    rst = 1'b0; l_rst = 1'b0;
    tick();

    // Plain frame A5
    pdata = 8'hA5; lvalid = 1'b1;
    tick();
    lvalid = 1'b0; pdata = 8'h00;
    expect_frame("a5", 8'hA5, -1, 0);
    chk_idle("a5_end");
    chk("a5_end_lready", lready, 1'b1);

    // A5 with a two-cycle stall at bit index 2
    pdata = 8'hA5; lvalid = 1'b1;
    tick();
    lvalid = 1'b0;
    expect_frame("stall", 8'hA5, 2, 2);
    chk_idle("stall_end");

    // Gap-free chain 3C then FF
    pdata = 8'h3C; lvalid = 1'b1;
    tick();
    pdata = 8'hFF;
    pair = {8'h3C, 8'hFF};
    for (int i = 0; i < 16; i++) begin
      chk("chain_valid", svalid, 1'b1);
      chk("chain_bit", sdata, pair[15-i]);
      chk("chain_last", last, (i % 8 == 7));
      chk("chain_lready", lready, (i % 8 == 7));
      tick();
      if (i == 7) lvalid = 1'b0;
    end
    chk_idle("chain_end");

    // Async reset mid-frame of F0
    pdata = 8'hF0; lvalid = 1'b1;
    tick();
    lvalid = 1'b0;
    repeat (4) tick();
    chk("f0_pre_bit", sdata, 1'b0);
    chk("f0_pre_busy", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk_idle("abort");
    chk("abort_lready", lready, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    pdata = 8'h81; lvalid = 1'b1;
    tick();
    lvalid = 1'b0;
    expect_frame("post_rst", 8'h81, -1, 0);
    chk_idle("post_rst_end");

    // LSB-first instance, word 01
    l_pdata = 8'h01; l_lvalid = 1'b1;
    tick();
    l_lvalid = 1'b0;
    w = 8'h01;
    for (int i = 0; i < 8; i++) begin
      chk("lsb_valid", l_svalid, 1'b1);
      chk("lsb_bit", l_sdata, w[i]);
      chk("lsb_last", l_last, (i == 7));
      tick();
    end
    chk("lsb_end_valid", l_svalid, 1'b0);
    chk("lsb_end_data", l_sdata, 1'b0);

    // 55 offered during AA; only captured on AA's final beat
    pdata = 8'hAA; lvalid = 1'b1;
    tick();
    lvalid = 1'b0; pdata = 8'h55;
    pair = {8'hAA, 8'h55};
    for (int i = 0; i < 16; i++) begin
      if (i == 2) lvalid = 1'b1;
      chk("hold_valid", svalid, 1'b1);
      chk("hold_bit", sdata, pair[15-i]);
      chk("hold_last", last, (i % 8 == 7));
      tick();
      if (i == 7) lvalid = 1'b0;
    end
    chk_idle("hold_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
